// File: rtl/uart_tx_periph_pkg.sv
// ============================================================================
// Module      : uart_tx_periph_pkg
// Description : Shared types and constants for the memory-mapped UART
//               transmitter: bus word types, the zero read word, the FSM
//               state enumeration and the register offsets (addr[3:2]).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_periph_pkg;

    typedef logic [31:0] MemAddrBus;
    typedef logic [31:0] MemBus;

    localparam MemBus ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Register selects, taken from addr[3:2]
    localparam logic [1:0] UART_CTRL   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam logic [1:0] UART_TXDATA = 2'd3;

endpackage

`default_nettype wire

// File: rtl/uart_tx_periph_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth. A push is accepted
//               when not full, or when a pop happens in the same cycle.
//               Pops on an empty FIFO are ignored. Head data is presented
//               combinationally on data_o.
// Ports       : clk, rst (sync, active-high), push_i, data_i, pop_i,
//               data_o, full_o, empty_o, count_o (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // When full, the slot being written is the one being read this cycle;
    // the read is combinational so the head byte leaves before it is replaced.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observable when count > 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_periph.sv
// ============================================================================
// Module      : uart_tx_periph
// Description : Memory-mapped 8N1 UART transmitter with a TX FIFO and a
//               programmable baud divisor. Registers (addr[3:2]):
//                 0x0 CTRL   : bit0 tx_en, bit1 irq_en (irq build only)
//                 0x4 STATUS : bit0 busy, bit1 full, bit2 empty,
//                              bits[5:3] count, bit6 overflow (W1C)
//                 0x8 BAUD   : bits[15:0] divisor D (0 behaves as 1)
//                 0xC TXDATA : write pushes wdata[7:0], reads 0
//               Optional feature macro: UART_TX_IRQ_EN adds irq_en and the
//               registered uart_irq output (TX idle and FIFO empty).
// Ports       : clk, rst (sync, active-high), waddr/wdata/we (write port),
//               raddr/rdata (combinational read), txd (idle high),
//               uart_irq (UART_TX_IRQ_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RST   = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic [31:0] raddr,
    output logic [31:0] rdata,
    output logic        txd
`ifdef UART_TX_IRQ_EN
    ,
    output logic        uart_irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = UART_IDLE;
    localparam logic [1:0] ST_START = UART_START;
    localparam logic [1:0] ST_DATA  = UART_DATA;
    localparam logic [1:0] ST_STOP  = UART_STOP;

    // Registers
    logic        tx_en_q,  tx_en_d;
    logic        irq_en;
    logic [15:0] baud_q,   baud_d;
    logic        ovf_q,    ovf_d;
    logic [1:0]  state_q,  state_d;
    logic [15:0] bitcnt_q, bitcnt_d;
    logic [2:0]  bitidx_q, bitidx_d;
    logic [7:0]  shreg_q,  shreg_d;
    logic        txd_q,    txd_d;

    // FIFO interface
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [2:0]    count3;

    logic          wr_any;
    logic [1:0]    wsel;
    logic [15:0]   div;
    logic          bit_end;
    logic          can_start;
    logic          unused_bits;

    assign wr_any    = |we;
    assign wsel      = waddr[3:2];
    assign div       = (baud_q == 16'd0) ? 16'd1 : baud_q;
    assign bit_end   = (bitcnt_q == 16'd0);
    assign can_start = tx_en_q && !fifo_empty;
    assign count3    = 3'(fifo_count);
    assign txd       = txd_q;

    // Address bits above the register select are decoded upstream.
    assign unused_bits = ^{waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0],
                           wdata[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (wdata[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_comb begin
        tx_en_d   = tx_en_q;
        baud_d    = baud_q;
        ovf_d     = ovf_q;
        fifo_push = 1'b0;
        if (wr_any) begin
            case (wsel)
                UART_CTRL: begin
                    if (we[0]) tx_en_d = wdata[0];
                end
                UART_STATUS: begin
                    if (we[0] && wdata[6]) ovf_d = 1'b0;
                end
                UART_BAUD: begin
                    if (we[0]) baud_d[7:0]  = wdata[7:0];
                    if (we[1]) baud_d[15:8] = wdata[15:8];
                end
                UART_TXDATA: begin
                    fifo_push = we[0];
                end
                default: ;
            endcase
        end
        // Dropped byte: FIFO full and nothing leaving this cycle.
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_any && (wsel == UART_CTRL) && we[0]) begin
            irq_en_d = wdata[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q && fifo_empty && (state_q == ST_IDLE);
        end
    end

    assign irq_en   = irq_en_q;
    assign uart_irq = irq_q;
`else
    assign irq_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transmit FSM. bitcnt counts the remaining cycles of the current bit;
    // every reload reads baud_q, so a BAUD write lands at the next bit.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;

        if ((state_q != ST_IDLE) && !bit_end) begin
            bitcnt_d = bitcnt_q - 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (can_start) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_data;
                    txd_d    = 1'b0;
                    bitcnt_d = div - 16'd1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    txd_d    = shreg_q[0];
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    bitidx_d = 3'd0;
                    bitcnt_d = div - 16'd1;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    bitcnt_d = div - 16'd1;
                    if (bitidx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        txd_d    = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        bitidx_d = bitidx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (can_start) begin
                        // Chain straight into the next start bit.
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_data;
                        txd_d    = 1'b0;
                        bitcnt_d = div - 16'd1;
                        state_d  = ST_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en_q  <= 1'b0;
            baud_q   <= BAUD_RST;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            bitcnt_q <= 16'd0;
            bitidx_q <= 3'd0;
            shreg_q  <= 8'd0;
            txd_q    <= 1'b1;
        end else begin
            tx_en_q  <= tx_en_d;
            baud_q   <= baud_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read path
    // ------------------------------------------------------------------
    always_comb begin
        rdata = ZeroWord;
        case (raddr[3:2])
            UART_CTRL: begin
                rdata[0] = tx_en_q;
                rdata[1] = irq_en;
            end
            UART_STATUS: begin
                rdata[0]   = (state_q != ST_IDLE);
                rdata[1]   = fifo_full;
                rdata[2]   = fifo_empty;
                rdata[5:3] = count3;
                rdata[6]   = ovf_q;
            end
            UART_BAUD: begin
                rdata[15:0] = baud_q;
            end
            default: rdata = ZeroWord;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
// ============================================================================
// Module      : tb_uart_tx_periph
// Description : Self-checking bench for uart_tx_periph. Bytes expected on
//               the line are queued when written; a serial receiver process
//               decodes every frame from txd and compares against the queue.
//               Register reads are checked against values derived from the
//               register map. Build with UART_TX_IRQ_EN for the irq variant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_periph;
    import uart_tx_periph_pkg::*;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  we    = '0;
    logic [31:0] raddr = '0;
    logic [31:0] rdata;
    logic        txd;
`ifdef UART_TX_IRQ_EN
    logic        uart_irq;
`endif

    uart_tx_periph #(
        .FIFO_DEPTH (4),
        .BAUD_RST   (16'd868)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .waddr (waddr),
        .wdata (wdata),
        .we    (we),
        .raddr (raddr),
        .rdata (rdata),
        .txd   (txd)
`ifdef UART_TX_IRQ_EN
        ,
        .uart_irq (uart_irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void check(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard and serial receiver
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         mon_d = 868;
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [9:0] mon_bits = '0;

    // A frame is 10 bit times of mon_d cycles; each bit is sampled near
    // its middle. Reset abandons any frame in progress.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && (txd == 1'b0)) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                start_q.push_back(cyc);
            end
            if (mon_active) begin
                if ((mon_cnt % mon_d) == ((mon_d - 1) / 2)) begin
                    mon_bits[mon_cnt / mon_d] = txd;
                end
                mon_cnt++;
                if (mon_cnt == 10 * mon_d) begin
                    mon_active = 1'b0;
                    check("start_bit", mon_bits[0], 0);
                    check("stop_bit", mon_bits[9], 1);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", mon_bits[8:1]);
                    end else begin
                        check("frame_data", mon_bits[8:1], exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus helpers
    // ------------------------------------------------------------------
    int last_wr_cyc = 0;

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] ad;
        ad = $urandom();
        ad[3:2] = a;
        @(posedge clk);
        #1;
        waddr = ad;
        wdata = d;
        we    = be;
        last_wr_cyc = cyc;
        @(posedge clk);
        #1;
        we    = 4'b0000;
        wdata = $urandom();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        logic [31:0] ad;
        ad = $urandom();
        ad[3:2] = a;
        raddr = ad;
        #1;
        d = rdata;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        logic [31:0] s;
        int left;
        left = budget;
        forever begin
            rd(UART_STATUS, s);
            if (!s[0] && (exp_q.size() == 0) && !mon_active) break;
            if (left == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: timeout, %0d bytes still expected", name, exp_q.size());
                break;
            end
            left--;
            tick(1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int          a;
        int          d;
        int          nb;
        bit          stayed_high;

        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        rd(UART_STATUS, r); check("reset_status", r, 32'h04);
        rd(UART_BAUD, r);   check("reset_baud", r, 868);
        rd(UART_CTRL, r);   check("reset_ctrl", r, 0);
        rd(UART_TXDATA, r); check("txdata_reads_zero", r, 0);
        check("reset_txd", txd, 1);
`ifdef UART_TX_IRQ_EN
        check("reset_irq", uart_irq, 0);
`endif

        // Byte-enable on BAUD: only byte 1 replaced
        wr(UART_BAUD, 32'h0000_1200, 4'b0010);
        rd(UART_BAUD, r); check("baud_byte1", r, 32'h1264);

        // Single frame 0x55, D = 4: latency and exact 40-cycle frame
        wr(UART_BAUD, 32'd4, 4'b0011);
        mon_d = 4;
        wr(UART_CTRL, 32'h1, 4'b0001);
        start_q.delete();
        exp_q.push_back(8'h55);
        wr(UART_TXDATA, 32'h55, 4'b0001);
        a = last_wr_cyc;
        tick(40);
        rd(UART_STATUS, r); check("busy_last_stop_cycle", r[0], 1);
        tick(1);
        rd(UART_STATUS, r); check("busy_cleared", r[0], 0);
        check("frame_0x55_received", exp_q.size(), 0);
        check("start_latency", (start_q.size() > 0) ? start_q[0] - a : -1, 2);

        // Overflow with tx disabled, then back-to-back drain
        wr(UART_CTRL, 32'h0, 4'b0001);
        wr(UART_BAUD, 32'd3, 4'b0011);
        mon_d = 3;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom());
            if (i < 4) exp_q.push_back(b);
            wr(UART_TXDATA, {24'($urandom()), b}, 4'b0001);
        end
        rd(UART_STATUS, r); check("status_full_ovf", r, 32'h62);
        wr(UART_STATUS, 32'h40, 4'b0001);
        rd(UART_STATUS, r); check("status_ovf_cleared", r, 32'h22);
        start_q.delete();
        wr(UART_CTRL, 32'h3, 4'b0001);
        rd(UART_CTRL, r);
`ifdef UART_TX_IRQ_EN
        check("ctrl_readback", r, 3);
`else
        check("ctrl_readback", r, 1);
`endif
        wait_drain("drain4", 400);
        check("frames_sent", start_q.size(), 4);
        if (start_q.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("no_gap", start_q[i] - start_q[i-1], 30);
            end
        end

        // D = 0 behaves as 1-cycle bits
        wr(UART_BAUD, 32'd0, 4'b0011);
        rd(UART_BAUD, r); check("baud_zero", r, 0);
        mon_d = 1;
        b = 8'($urandom());
        exp_q.push_back(b);
        wr(UART_TXDATA, {24'h0, b}, 4'b0001);
        wait_drain("baud_zero_frame", 60);

        // Randomised bursts with random divisors
        for (int it = 0; it < 8; it++) begin
            d  = $urandom_range(0, 6);
            nb = $urandom_range(1, 4);
            wr(UART_BAUD, 32'(d), 4'b0011);
            mon_d = (d == 0) ? 1 : d;
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom());
                exp_q.push_back(b);
                wr(UART_TXDATA, {24'($urandom()), b}, 4'b0001);
            end
            wait_drain("random_burst", 10 * mon_d * nb + 50);
        end

        // Reset during DATA of 0xA3
        wr(UART_BAUD, 32'd4, 4'b0011);
        mon_d = 4;
        wr(UART_TXDATA, 32'hA3, 4'b0001);
        tick(14);
        rst = 1'b1;
        tick(1);
        check("rst_txd_high", txd, 1);
        rd(UART_STATUS, r); check("rst_status", r, 32'h04);
        rd(UART_BAUD, r);   check("rst_baud", r, 868);
        rst = 1'b0;
        stayed_high = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (txd !== 1'b1) stayed_high = 1'b0;
        end
        check("no_residual_bits", stayed_high, 1);

`ifdef UART_TX_IRQ_EN
        // Idle interrupt behaviour
        wr(UART_BAUD, 32'd2, 4'b0011);
        mon_d = 2;
        wr(UART_CTRL, 32'h3, 4'b0001);
        tick(1);
        check("irq_idle_high", uart_irq, 1);
        b = 8'($urandom());
        exp_q.push_back(b);
        wr(UART_TXDATA, {24'h0, b}, 4'b0001);
        tick(1);
        check("irq_dropped_by_write", uart_irq, 0);
        begin
            int left;
            left = 100;
            forever begin
                rd(UART_STATUS, r);
                if (!r[0] || left == 0) break;
                left--;
                tick(1);
            end
            check("irq_busy_cleared", r[0], 0);
        end
        check("irq_low_on_idle_entry", uart_irq, 0);
        tick(1);
        check("irq_rises", uart_irq, 1);
        wait_drain("irq_frame", 40);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter that hangs directly off one slave port of the RISC-V core's data bus decoder. It sits downstream of that decoder and consumes its slave write/read signals. It buffers bytes written by the core in a 4-entry FIFO and serialises them 8N1 on `txd` with a programmable baud divisor. Status is readable combinationally in the same cycle, matching the bus's zero-wait read path.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of two ≥ 2.
- `BAUD_RST`, 16'd868: reset value of the BAUD register (100 MHz / 115200).

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `waddr` in MemAddrBus: write address from the bus slave port.
- `wdata` in MemBus: write data.
- `we` in 4: byte write enables. A write occurs when any bit is set.
- `raddr` in MemAddrBus: read address.
- `rdata` out MemBus: combinational read data.
- `txd` out 1: serial output, registered, idle high.
- `uart_irq` out 1: TX-idle interrupt, registered. Only present with `UART_TX_IRQ_EN`.

## Operation
- Register decode uses `addr[3:2]`. Upper bits are ignored; the upstream decoder has already selected this slave.
  - 0x0 CTRL: bit0 `tx_en`, bit1 `irq_en` (irq variant only). Reset 0.
  - 0x4 STATUS (read): bit0 busy (FSM≠IDLE), bit1 full, bit2 empty, bits[5:3] count (0..4), bit6 overflow (sticky).
  - 0x4 STATUS (write): writing 1 to bit6 with `we[0]` clears overflow.
  - 0x8 BAUD: bits[15:0] divisor D. Reset `BAUD_RST`. D = 0 is treated as 1. Bit period is D clock cycles.
  - 0xC TXDATA: a write with `we[0]` pushes `wdata[7:0]`. Reads return `ZeroWord`.
- CTRL and BAUD honour byte enables per byte. Unused bits read 0.
- FIFO push rules:
  - A push is accepted if count < 4, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP. Each bit lasts D cycles, counted by a 16-bit down-counter.
  - IDLE: when `tx_en && !empty`, pop into an 8-bit shift register and go to START.
  - START: `txd` = 0.
  - DATA: 8 bits, LSB first, then go to STOP.
  - STOP: `txd` = 1. At the end of the bit, if `tx_en && !empty`, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Clearing `tx_en` mid-frame: the current frame completes and no further pop occurs.
- A BAUD write mid-frame takes effect at the next bit-counter reload.
- `uart_irq` (irq variant) = registered `irq_en & empty & (state==IDLE)`.

## Timing
- Reset values:
  - `txd` = 1, `uart_irq` = 0.
  - FSM = IDLE, FIFO empty, overflow = 0, CTRL = 0, BAUD = `BAUD_RST`.
  - A reset mid-frame aborts the frame; `txd` is high at the next edge.
- Register writes take effect at the rising edge that ends the write cycle.
- `rdata` is combinational from `raddr` and current state, with no side effects.
- Latency with `tx_en` already set and FSM idle:
  - TXDATA write in cycle N.
  - FIFO non-empty in N+1; pop at the end of N+1.
  - `txd` falls in N+2.
- A frame is exactly 10·D cycles. Back-to-back frames have no gap.

## Configuration
- `UART_TX_IRQ_EN` defined:
  - CTRL bit1 `irq_en` exists.
  - The `uart_irq` port exists and behaves as described above.
- `UART_TX_IRQ_EN` undefined:
  - No `uart_irq` port.
  - CTRL bit1 reads 0 and writes to it are ignored.

## Structure
- `type_pkg` gains:
  - `uart_state_e` enum (IDLE, START, DATA, STOP).
  - Register offset constants: `UART_CTRL`, `UART_STATUS`, `UART_BAUD`, `UART_TXDATA`.
- `defines.sv` supplies `ZeroWord`. The macro is tested there or on the command line.
- One sub-module: `sync_fifo` (parameterised width/depth; push/pop/full/empty/count). Reusable for a later RX path.

## Test plan
- Reset, then read STATUS → 0x04 (empty). Read BAUD → 868. `txd` = 1.
- D = 4, `tx_en` = 1, write 0x55 to TXDATA in cycle N → `txd` falls in N+2. Bits 1,0,1,0,1,0,1,0 at 4-cycle intervals, then stop, for 40 cycles total. Busy clears afterwards.
- `tx_en` = 0, write 5 bytes → count = 4, full = 1, overflow = 1. Write 0x40 to STATUS → overflow = 0. Set `tx_en` → 4 frames sent back-to-back with no idle cycles.
- BAUD write with `we` = 4'b0010, wdata = 0x0000_1200 → BAUD = 0x1264 (low byte unchanged). Writing D = 0 yields 1-cycle bits.
- Assert `rst` during DATA of frame 0xA3 → next edge `txd` = 1, count = 0, state IDLE. No residual bits after deassert.
- With `UART_TX_IRQ_EN`: `irq_en` = 1, send one byte with D = 2 → `uart_irq` rises one cycle after the FSM returns to IDLE with FIFO empty. A new TXDATA write drops it.
